// File: rtl/rgb2gray_stream.sv
// RGB888 to 8-bit luminance AXI-stream converter with per-frame weight latching.
// Optional frame-length checking is enabled by defining RGB2GRAY_FRAME_CHECK_EN.
module rgb2gray_stream #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] s_axi_data,
    input  logic        s_axi_valid,
    input  logic        s_axi_keep,
    input  logic        s_axi_last,
    output logic        s_axi_ready,
    input  logic [7:0]  coe_r,
    input  logic [7:0]  coe_g,
    input  logic [7:0]  coe_b,
    output logic [7:0]  m_axi_data,
    output logic        m_axi_valid,
    output logic        m_axi_keep,
    output logic        m_axi_last,
    input  logic        m_axi_ready,
    output logic        frame_done,
    output logic        err_last
);

    logic        en;
    logic        accept;
    logic        in_last;

    logic        armed;
    logic [7:0]  wr, wg, wb;

    logic        v1, k1, l1;
    logic [7:0]  r1, g1, b1;

    logic        v2, k2, l2;
    logic [15:0] p_r, p_g, p_b;

    logic        v3, k3, l3;
    logic [17:0] sum3;

    assign en          = !m_axi_valid || m_axi_ready;
    assign s_axi_ready = en;
    assign accept      = s_axi_valid && en;
    assign frame_done  = m_axi_valid && m_axi_ready && m_axi_last;

`ifdef RGB2GRAY_FRAME_CHECK_EN
    localparam int PIXELS = IMG_W * IMG_H;
    localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PIXELS - 1);

    logic [CNT_W-1:0] pix_cnt;
    logic             at_end;
    logic             err_q;

    assign at_end   = (pix_cnt == CNT_MAX);
    assign in_last  = s_axi_last || at_end;
    assign err_last = err_q;

    // An early last is still forwarded, but flags the frame and restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            pix_cnt <= in_last ? '0 : pix_cnt + CNT_W'(1);
            if (s_axi_last && !at_end)
                err_q <= 1'b1;
        end
    end
`else
    assign in_last  = s_axi_last;
    assign err_last = 1'b0;
`endif

    // Weights change only with the first beat of a frame; the multiply of that beat
    // happens one edge later, so the beat ahead of it still sees the old set.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
            wr    <= '0;
            wg    <= '0;
            wb    <= '0;
        end else if (accept) begin
            armed <= in_last;
            if (armed) begin
                wr <= coe_r;
                wg <= coe_g;
                wb <= coe_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            k1 <= 1'b0;
            l1 <= 1'b0;
            r1 <= '0;
            g1 <= '0;
            b1 <= '0;
        end else if (en) begin
            v1 <= s_axi_valid;
            k1 <= s_axi_keep;
            l1 <= in_last;
            r1 <= s_axi_data[23:16];
            g1 <= s_axi_data[15:8];
            b1 <= s_axi_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            k2  <= 1'b0;
            l2  <= 1'b0;
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
        end else if (en) begin
            v2  <= v1;
            k2  <= k1;
            l2  <= l1;
            p_r <= 16'(r1) * 16'(wr);
            p_g <= 16'(g1) * 16'(wg);
            p_b <= 16'(b1) * 16'(wb);
        end
    end

    // The +128 rounds the 1/256-scaled sum to nearest.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3   <= 1'b0;
            k3   <= 1'b0;
            l3   <= 1'b0;
            sum3 <= '0;
        end else if (en) begin
            v3   <= v2;
            k3   <= k2;
            l3   <= l2;
            sum3 <= 18'(p_r) + 18'(p_g) + 18'(p_b) + 18'd128;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_valid <= 1'b0;
            m_axi_keep  <= 1'b0;
            m_axi_last  <= 1'b0;
            m_axi_data  <= '0;
        end else if (en) begin
            m_axi_valid <= v3;
            m_axi_keep  <= v3 && k3;
            m_axi_last  <= v3 && l3;
            m_axi_data  <= (sum3[17:16] != 2'b00) ? 8'hFF : sum3[15:8];
        end
    end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Self-checking bench for rgb2gray_stream: directed steps plus randomized streams
// compared against a behavioural queue model of the luminance conversion.
module tb_rgb2gray_stream;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int PIXELS = IMG_W * IMG_H;
`ifdef RGB2GRAY_FRAME_CHECK_EN
    localparam bit FRAME_CHECK = 1'b1;
`else
    localparam bit FRAME_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] s_axi_data;
    logic        s_axi_valid;
    logic        s_axi_keep;
    logic        s_axi_last;
    logic        s_axi_ready;
    logic [7:0]  coe_r, coe_g, coe_b;
    logic [7:0]  m_axi_data;
    logic        m_axi_valid;
    logic        m_axi_keep;
    logic        m_axi_last;
    logic        m_axi_ready;
    logic        frame_done;
    logic        err_last;

    typedef struct {
        logic [7:0] data;
        logic       keep;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      head;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    bit         armed;
    int         mwr, mwg, mwb;
    int         pix;
    bit         merr;

    bit         accepted;
    bit         held_valid;
    logic [7:0] held_data;
    logic       held_keep, held_last;
    bit         seen_valid;
    logic [7:0] seen_data;
    int         seen_cyc;
    int         fd_count;
    int         valid_count;
    int         lat_start;
    int         lat;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    rgb2gray_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi_data (s_axi_data),
        .s_axi_valid(s_axi_valid),
        .s_axi_keep (s_axi_keep),
        .s_axi_last (s_axi_last),
        .s_axi_ready(s_axi_ready),
        .coe_r      (coe_r),
        .coe_g      (coe_g),
        .coe_b      (coe_b),
        .m_axi_data (m_axi_data),
        .m_axi_valid(m_axi_valid),
        .m_axi_keep (m_axi_keep),
        .m_axi_last (m_axi_last),
        .m_axi_ready(m_axi_ready),
        .frame_done (frame_done),
        .err_last   (err_last)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input int r, input int g, input int b,
                                 input logic keep, input logic last);
        s_axi_valid = valid;
        s_axi_data  = {8'(r), 8'(g), 8'(b)};
        s_axi_keep  = keep;
        s_axi_last  = last;
    endtask

    task automatic model_reset();
        exp_q.delete();
        armed      = 1'b1;
        pix        = 0;
        merr       = 1'b0;
        held_valid = 1'b0;
    endtask

    // Reference: weights captured at frame start, gray = min(255, round(sum/256)).
    task automatic model_accept();
        beat_t e;
        int    sum;
        if (armed) begin
            mwr = int'(coe_r);
            mwg = int'(coe_g);
            mwb = int'(coe_b);
        end
        e.last = s_axi_last;
        if (FRAME_CHECK) begin
            if (pix == PIXELS - 1) e.last = 1'b1;
            else if (s_axi_last) merr = 1'b1;
            pix = e.last ? 0 : pix + 1;
        end
        armed  = e.last;
        sum    = int'(s_axi_data[23:16]) * mwr + int'(s_axi_data[15:8]) * mwg
               + int'(s_axi_data[7:0]) * mwb + 128;
        sum    = sum / 256;
        e.data = (sum > 255) ? 8'd255 : 8'(sum);
        e.keep = s_axi_keep;
        exp_q.push_back(e);
    endtask

    // One clock: sample and check at the falling edge, then advance past the rising edge.
    task automatic cycle();
        @(negedge clk);
        accepted   = 1'b0;
        seen_valid = m_axi_valid;
        seen_data  = m_axi_data;
        seen_cyc   = cyc;
        if (rst) begin
            model_reset();
        end else begin
            if (m_axi_valid) valid_count++;
            if (frame_done) fd_count++;
            checkOutput("s_ready_en", 32'(s_axi_ready), 32'(!m_axi_valid || m_axi_ready));
            checkOutput("err_last", 32'(err_last), 32'(merr));
            if (held_valid) begin
                checkOutput("hold_valid", 32'(m_axi_valid), 32'd1);
                checkOutput("hold_data", 32'(m_axi_data), 32'(held_data));
                checkOutput("hold_keep", 32'(m_axi_keep), 32'(held_keep));
                checkOutput("hold_last", 32'(m_axi_last), 32'(held_last));
            end
            if (m_axi_valid && m_axi_ready) begin
                checkOutput("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    checkOutput("out_data", 32'(m_axi_data), 32'(head.data));
                    checkOutput("out_keep", 32'(m_axi_keep), 32'(head.keep));
                    checkOutput("out_last", 32'(m_axi_last), 32'(head.last));
                    checkOutput("frame_done", 32'(frame_done), 32'(head.last));
                end
            end else begin
                checkOutput("frame_done_idle", 32'(frame_done), 32'd0);
            end
            held_valid = m_axi_valid && !m_axi_ready;
            held_data  = m_axi_data;
            held_keep  = m_axi_keep;
            held_last  = m_axi_last;
            if (s_axi_valid && s_axi_ready) begin
                accepted = 1'b1;
                model_accept();
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_beat(input int r, input int g, input int b, input logic keep, input logic last);
        int guard;
        applyStimulus(1'b1, r, g, b, keep, last);
        guard = 0;
        accepted = 1'b0;
        while (!accepted && guard < 50) begin
            cycle();
            guard++;
        end
        checkOutput("send_timeout", 32'(accepted), 32'd1);
        lat_start = cyc;
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_output(output int latency, output logic [7:0] data);
        latency = 99;
        data    = 8'h00;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (seen_valid) begin
                latency = seen_cyc - lat_start;
                data    = seen_data;
                break;
            end
        end
    endtask

    task automatic drain(input int n);
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
        m_axi_ready = 1'b1;
        for (int k = 0; k < n; k++) cycle();
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int k = 0; k < n; k++) cycle();
        rst = 1'b0;
    endtask

    // Random frame with gapped input and random downstream stalls; coe_g flips to 0 mid-frame.
    task automatic random_frame(input int n, input int g_change_at);
        int  idx;
        int  guard;
        bit  pend;
        idx   = 0;
        guard = 0;
        pend  = 1'b0;
        while (idx < n && guard < 600) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                applyStimulus(pend, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                              int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), idx == n - 1);
            end
            if (idx >= g_change_at) coe_g = 8'd0;
            m_axi_ready = 1'($urandom_range(0, 1));
            cycle();
            if (accepted) begin
                pend = 1'b0;
                idx++;
                applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
            end
            guard++;
        end
        checkOutput("stream_count", 32'(idx), 32'(n));
    endtask

    initial begin
        rst         = 1'b1;
        m_axi_ready = 1'b1;
        coe_r       = 8'd77;
        coe_g       = 8'd150;
        coe_b       = 8'd29;
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
        model_reset();

        do_reset(3);
        checkOutput("rst_m_valid", 32'(m_axi_valid), 32'd0);
        checkOutput("rst_m_data", 32'(m_axi_data), 32'd0);
        checkOutput("rst_m_last", 32'(m_axi_last), 32'd0);
        checkOutput("rst_m_keep", 32'(m_axi_keep), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_err_last", 32'(err_last), 32'd0);
        checkOutput("rst_s_ready", 32'(s_axi_ready), 32'd1);

        $display("[TB] weights 77/150/29, latency and known values");
        send_beat(255, 255, 255, 1'b1, 1'b0);
        wait_output(lat, out_data);
        checkOutput("latency_white", 32'(lat), 32'd3);
        checkOutput("gray_white", 32'(out_data), 32'd255);
        send_beat(100, 50, 0, 1'b1, 1'b1);
        wait_output(lat, out_data);
        checkOutput("latency_mixed", 32'(lat), 32'd3);
        checkOutput("gray_mixed", 32'(out_data), 32'd59);
        drain(4);

        $display("[TB] weights 255/255/255, saturation");
        coe_r = 8'd255;
        coe_g = 8'd255;
        coe_b = 8'd255;
        send_beat(255, 255, 255, 1'b1, 1'b0);
        wait_output(lat, out_data);
        checkOutput("gray_saturate", 32'(out_data), 32'd255);
        send_beat(0, 0, 0, 1'b0, 1'b1);
        wait_output(lat, out_data);
        checkOutput("gray_black", 32'(out_data), 32'd0);
        drain(4);

        $display("[TB] random streams with stalls and mid-frame weight change");
        coe_r = 8'd77;
        coe_g = 8'd150;
        coe_b = 8'd29;
        random_frame(16, 8);
        random_frame(8, 0);
        drain(10);

        $display("[TB] frame length check");
        do_reset(2);
        fd_count = 0;
        for (int k = 0; k < PIXELS; k++)
            send_beat(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), 1'b1, 1'b0);
        drain(8);
        checkOutput("frame_done_count", 32'(fd_count), FRAME_CHECK ? 32'd1 : 32'd0);
        for (int k = 0; k < 5; k++)
            send_beat(10 * k, 20, 30, 1'b1, k == 4);
        drain(8);
        checkOutput("err_after_early_last", 32'(err_last), FRAME_CHECK ? 32'd1 : 32'd0);
        drain(3);
        checkOutput("err_sticky", 32'(err_last), FRAME_CHECK ? 32'd1 : 32'd0);
        do_reset(1);
        checkOutput("err_cleared", 32'(err_last), 32'd0);

        $display("[TB] reset with beats in flight");
        m_axi_ready = 1'b1;
        applyStimulus(1'b1, 200, 100, 50, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 10, 20, 30, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 90, 80, 70, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
        do_reset(1);
        checkOutput("flush_valid", 32'(m_axi_valid), 32'd0);
        valid_count = 0;
        drain(10);
        checkOutput("flush_no_stale", 32'(valid_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb2gray_stream.md
# rgb2gray_stream

Upstream front-end of the edge-detection pipeline. Accepts a 24-bit RGB AXI-stream, converts each pixel to 8-bit luminance with programmable weights, and presents an 8-bit AXI-stream that drives the core's gray pixel input (`axi_data_in`, `input_axi_valid`/`ready`/`last`/`keep`). It is a 3-stage, fully back-pressurable pipeline. Weights are latched per frame, so a frame is never converted with mixed weights.

## Interface
- `IMG_W`, default 512: pixels per line (used only by the frame check).
- `IMG_H`, default 512: lines per frame (used only by the frame check).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `s_axi_data` in 24: R=[23:16], G=[15:8], B=[7:0].
- `s_axi_valid` in 1: input beat valid.
- `s_axi_keep` in 1: input keep.
- `s_axi_last` in 1: last pixel of frame.
- `s_axi_ready` out 1: input accepted when high with valid.
- `coe_r`, `coe_g`, `coe_b` in 8 each: unsigned weights, scale 1/256.
- `m_axi_data` out 8: gray pixel.
- `m_axi_valid` out 1: output beat valid.
- `m_axi_keep` out 1: delayed copy of `s_axi_keep`.
- `m_axi_last` out 1: frame end.
- `m_axi_ready` in 1: downstream ready.
- `frame_done` out 1: one-cycle pulse when a beat with `m_axi_last=1` transfers.
- `err_last` out 1: sticky frame-length error; tied 0 without the macro.

## Operation
- Global enable: `en = !m_axi_valid || m_axi_ready`. `s_axi_ready = en`.
- All pipeline stages advance only when `en` is high. Each stage carries a valid bit plus `keep`/`last` sidebands.
- S1 (on accept): register R, G, B and the sidebands. Before the stage-1 products are used, the active weights must already be the latched set for this frame.
- S2: products `R*wr`, `G*wg`, `B*wb`, each 16-bit unsigned.
- S3: `sum = p_r + p_g + p_b + 128` at 18 bits; `gray = sum[17:8]`, saturated to 255 if it exceeds 255. Registered into `m_axi_data`.
- Weight latch: `wr`/`wg`/`wb` load from `coe_*` on the first accepted beat after reset or after an accepted `s_axi_last` beat. The loaded values apply to that beat. `coe_*` changes at any other time are ignored until the next frame start.
- Bubbles (empty slots) propagate as invalid slots. A full pipeline with `m_axi_ready=0` holds every stage.
- `rst` mid-frame: all valids clear, the pixel counter clears, `err_last` clears, and the weight latch re-arms. Beats in flight are discarded.

## Timing
- Reset values: `m_axi_valid=0`, `m_axi_data=0`, `m_axi_last=0`, `m_axi_keep=0`, `frame_done=0`, `err_last=0`. `s_axi_ready=1` from the first cycle after reset.
- Latency: a beat accepted at edge N appears on `m_axi_*` after edge N+3 when unstalled.
- Throughput: 1 pixel/clk.
- `m_axi_data`, `m_axi_last`, and `m_axi_keep` stay stable while `m_axi_valid=1 && m_axi_ready=0`.
- A transfer on both sides in the same cycle is allowed. `en` is a combinational function of `m_axi_ready`.

## Configuration
- Macro `RGB2GRAY_FRAME_CHECK_EN`.
- Defined: a pixel counter of width `$clog2(IMG_W*IMG_H)` counts accepted beats.
  - When the counter reaches `IMG_W*IMG_H-1`, that beat gets `last` forced to 1 and the counter wraps to 0.
  - An input `last` arriving at any other count sets `err_last`, which stays set until `rst`. That `last` is still forwarded and the counter resets to 0.
- Undefined:
  - No counter.
  - `last` passes through unchanged.
  - `err_last` is constant 0.

## Test plan
- Weights 77/150/29, input (255,255,255) → `m_axi_data=255` exactly 3 cycles after accept; input (100,50,0) → 59.
- Weights 255/255/255, input (255,255,255) → saturates to 255; input (0,0,0) → 0.
- Stream 16 beats with `m_axi_ready` toggled pseudo-randomly → output sequence identical and in order, with no beat lost or duplicated. Data holds while stalled, and `s_axi_ready` tracks `en`.
- Change `coe_g` from 150 to 0 mid-frame → the remaining pixels of the frame still use 150. The first pixel after `last` uses 0.
- With the macro, `IMG_W=4`, `IMG_H=2`: 8 beats with no `last` → beat 8 emits `m_axi_last=1` and `frame_done` pulses. Sending `last` on beat 5 sets `err_last=1`, which stays set until `rst`.
- Assert `rst` with 3 beats in flight → `m_axi_valid=0` on the next cycle and no stale beat emerges afterwards.
